// File: rtl/intr_ctrl_if.sv
// Bus bundle between the interrupt controller and its surroundings (sources, PC controller).
// The controller takes the slave modport; the stimulus/CPU side takes master.
interface intr_ctrl_if;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       ack;
  logic       iret;
  logic       interrupt;
  logic [2:0] vector_id;
  logic [7:0] pending;
  logic [7:0] mask;
  logic [7:0] in_service;
  logic       err;

  modport master (
    output irq_in, mask_wr, mask_data, ack, iret,
    input  interrupt, vector_id, pending, mask, in_service, err
  );

  modport slave (
    input  irq_in, mask_wr, mask_data, ack, iret,
    output interrupt, vector_id, pending, mask, in_service, err
  );
endinterface

// File: rtl/intr_ctrl.sv
// 8-source fixed-priority interrupt controller (index 0 highest) with mask and in-service tracking.
// Define INTR_NEST_EN to let a higher-priority source pre-empt a source already in service.
module intr_ctrl #(
  parameter logic [7:0] EDGE_MASK = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  intr_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] irq_prev_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] in_service_q, in_service_d;
  logic       interrupt_q, interrupt_d;
  logic [2:0] vector_q, vector_d;
  logic       err_q, err_d;

  logic [7:0] rise;
  logic [7:0] eligible_raw;
  logic [7:0] eligible;
  logic [7:0] ack_clr;
  logic [7:0] edge_pend;
  logic       ack_ok;
  logic       iret_ok;

  function automatic logic [2:0] prio_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] lowest_bit(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  // Eligibility and pending-vector update
  always_comb begin
    rise         = bus.irq_in & ~irq_prev_q;
    eligible_raw = pending_q & ~mask_q & ~in_service_q;
`ifdef INTR_NEST_EN
    // Only sources strictly above the innermost serviced one may nest
    eligible = (in_service_q == 8'h00) ? eligible_raw
                                       : (eligible_raw & (lowest_bit(in_service_q) - 8'd1));
`else
    eligible = (in_service_q == 8'h00) ? eligible_raw : 8'h00;
`endif
    ack_ok    = bus.ack && (state_q == REQ);
    iret_ok   = bus.iret && !bus.ack && (in_service_q != 8'h00);
    ack_clr   = ack_ok ? (8'h01 << vector_q) : 8'h00;
    // A fresh edge in the ack cycle survives the clear
    edge_pend = (pending_q & ~ack_clr) | rise;
    pending_d = (EDGE_MASK & edge_pend) | (~EDGE_MASK & bus.irq_in);
    mask_d    = bus.mask_wr ? bus.mask_data : mask_q;
    err_d     = err_q
              | (bus.ack && (state_q != REQ))
              | (bus.iret && (bus.ack || (in_service_q == 8'h00)));
  end

  // FSM next state and request outputs
  always_comb begin
    state_d      = state_q;
    interrupt_d  = interrupt_q;
    vector_d     = vector_q;
    in_service_d = in_service_q;

    if (iret_ok) begin
      in_service_d = in_service_q & ~lowest_bit(in_service_q);
    end

    case (state_q)
      IDLE: begin
        if (eligible != 8'h00) begin
          state_d     = REQ;
          interrupt_d = 1'b1;
          vector_d    = prio_idx(eligible);
        end
      end
      REQ: begin
        if (ack_ok) begin
          in_service_d = in_service_q | (8'h01 << vector_q);
          interrupt_d  = 1'b0;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (in_service_d == 8'h00) begin
          state_d = IDLE;
        end else if (eligible != 8'h00) begin
          state_d     = REQ;
          interrupt_d = 1'b1;
          vector_d    = prio_idx(eligible);
        end
      end
      default: begin
        state_d     = IDLE;
        interrupt_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_prev_q   <= 8'h00;
      pending_q    <= 8'h00;
      mask_q       <= 8'hFF;
      in_service_q <= 8'h00;
      interrupt_q  <= 1'b0;
      vector_q     <= 3'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= bus.irq_in;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      interrupt_q  <= interrupt_d;
      vector_q     <= vector_d;
      err_q        <= err_d;
    end
  end

  assign bus.interrupt  = interrupt_q;
  assign bus.vector_id  = vector_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;
  assign bus.in_service = in_service_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized traffic against a reference model.
// Source 4 is level-triggered, all others edge-triggered.
module tb_intr_ctrl;
  localparam logic [7:0] TB_EDGE = 8'hEF;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  intr_ctrl_if bus();

  intr_ctrl #(.EDGE_MASK(TB_EDGE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: phase 0=idle, 1=requesting, 2=servicing
  int         m_phase;
  logic       m_int;
  logic [2:0] m_vec;
  logic [7:0] m_pend, m_prev, m_mask, m_isr;
  logic       m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [7:0] elig, np, isr_n, edge_v;
    int low, win;
    bit ack_ok;
    if (reset) begin
      m_phase = 0; m_int = 0; m_vec = 0; m_pend = 0; m_prev = 0;
      m_mask = 8'hFF; m_isr = 0; m_err = 0;
      return;
    end
    edge_v = TB_EDGE;
    low = 8;
    for (int i = 7; i >= 0; i--) if (m_isr[i]) low = i;
    elig = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_pend[i] && !m_mask[i] && !m_isr[i]) begin
`ifdef INTR_NEST_EN
        if (i < low) elig[i] = 1'b1;
`else
        if (m_isr == 0) elig[i] = 1'b1;
`endif
      end
    end
    win = -1;
    for (int i = 7; i >= 0; i--) if (elig[i]) win = i;
    ack_ok = bus.ack && (m_phase == 1);
    for (int i = 0; i < 8; i++) begin
      if (edge_v[i])
        np[i] = (bus.irq_in[i] && !m_prev[i]) || (m_pend[i] && !(ack_ok && (i == int'(m_vec))));
      else
        np[i] = bus.irq_in[i];
    end
    if (bus.ack && m_phase != 1) m_err = 1;
    if (bus.iret && (bus.ack || m_isr == 0)) m_err = 1;
    isr_n = m_isr;
    if (bus.iret && !bus.ack && m_isr != 0) isr_n[low] = 1'b0;
    case (m_phase)
      0: if (win >= 0) begin m_phase = 1; m_int = 1; m_vec = win[2:0]; end
      1: if (ack_ok) begin isr_n[m_vec] = 1'b1; m_int = 0; m_phase = 2; end
      default: begin
        if (isr_n == 0) m_phase = 0;
        else if (win >= 0) begin m_phase = 1; m_int = 1; m_vec = win[2:0]; end
      end
    endcase
    m_pend = np;
    m_prev = bus.irq_in;
    m_isr  = isr_n;
    if (bus.mask_wr) m_mask = bus.mask_data;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("interrupt",  {31'd0, bus.interrupt}, {31'd0, m_int});
    chk("vector_id",  {29'd0, bus.vector_id}, {29'd0, m_vec});
    chk("pending",    {24'd0, bus.pending},   {24'd0, m_pend});
    chk("mask",       {24'd0, bus.mask},      {24'd0, m_mask});
    chk("in_service", {24'd0, bus.in_service},{24'd0, m_isr});
    chk("err",        {31'd0, bus.err},       {31'd0, m_err});
    @(negedge clk);
    bus.ack = 0; bus.iret = 0; bus.mask_wr = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic wr_mask(input logic [7:0] v);
    bus.mask_wr = 1; bus.mask_data = v; tick();
  endtask

  initial begin
    logic [7:0] r;
    logic       lvl;
    reset = 1;
    bus.irq_in = 0; bus.mask_wr = 0; bus.mask_data = 0; bus.ack = 0; bus.iret = 0;
    m_phase = 0; m_int = 0; m_vec = 0; m_pend = 0; m_prev = 0; m_mask = 8'hFF; m_isr = 0; m_err = 0;
    @(negedge clk);
    tick(); tick(); reset = 0;
    chk("rst_mask", {24'd0, bus.mask}, 32'hFF);
    chk("rst_int",  {31'd0, bus.interrupt}, 32'd0);
    chk("rst_isr",  {24'd0, bus.in_service}, 32'd0);

    // Single edge source
    wr_mask(8'h00);
    bus.irq_in = 8'h08; tick(); bus.irq_in = 8'h00; tick();
    chk("s1_int", {31'd0, bus.interrupt}, 32'd1);
    chk("s1_vec", {29'd0, bus.vector_id}, 32'd3);
    bus.ack = 1; tick();
    chk("s1_ack_int", {31'd0, bus.interrupt}, 32'd0);
    chk("s1_ack_isr", {24'd0, bus.in_service}, 32'h08);
    chk("s1_ack_pend", {24'd0, bus.pending}, 32'h00);
    bus.iret = 1; tick();
    chk("s1_iret_isr", {24'd0, bus.in_service}, 32'h00);

    // Two simultaneous sources: priority then the loser
    bus.irq_in = 8'h24; tick(); bus.irq_in = 8'h00; tick();
    chk("s2_vec_a", {29'd0, bus.vector_id}, 32'd2);
    bus.ack = 1; tick(); bus.iret = 1; tick(); tick();
    chk("s2_int_b", {31'd0, bus.interrupt}, 32'd1);
    chk("s2_vec_b", {29'd0, bus.vector_id}, 32'd5);
    bus.ack = 1; tick(); bus.iret = 1; tick();

    // Masked source is held pending, released on unmask
    wr_mask(8'h01);
    bus.irq_in = 8'h01; tick(); bus.irq_in = 8'h00; tick(); tick();
    chk("s3_int_masked", {31'd0, bus.interrupt}, 32'd0);
    chk("s3_pend", {24'd0, bus.pending}, 32'h01);
    wr_mask(8'h00); tick();
    chk("s3_int", {31'd0, bus.interrupt}, 32'd1);
    chk("s3_vec", {29'd0, bus.vector_id}, 32'd0);
    bus.ack = 1; tick(); bus.iret = 1; tick();

    // Level source dropped while requesting
    bus.irq_in = 8'h10; tick(); tick(); bus.irq_in = 8'h00; tick();
    chk("s4_int_held", {31'd0, bus.interrupt}, 32'd1);
    chk("s4_vec", {29'd0, bus.vector_id}, 32'd4);
    tick(); bus.ack = 1; tick();
    chk("s4_isr", {24'd0, bus.in_service}, 32'h10);
    bus.iret = 1; tick();

    // Protocol errors
    bus.ack = 1; tick();
    chk("s5_err", {31'd0, bus.err}, 32'd1);
    chk("s5_isr", {24'd0, bus.in_service}, 32'h00);
    bus.iret = 1; tick();
    chk("s5_err_stay", {31'd0, bus.err}, 32'd1);
    do_reset();
    chk("s5_err_clr", {31'd0, bus.err}, 32'd0);
    chk("s5_mask_rst", {24'd0, bus.mask}, 32'hFF);

    // ack and iret together
    wr_mask(8'h00);
    bus.irq_in = 8'h80; tick(); bus.irq_in = 8'h00; tick();
    bus.ack = 1; bus.iret = 1; tick();
    chk("s6_isr", {24'd0, bus.in_service}, 32'h80);
    chk("s6_err", {31'd0, bus.err}, 32'd1);
    bus.iret = 1; tick();
    do_reset();

    // Reset while requesting drops the request
    wr_mask(8'h00);
    bus.irq_in = 8'h04; tick(); bus.irq_in = 8'h00; tick();
    chk("s7_int", {31'd0, bus.interrupt}, 32'd1);
    do_reset();
    chk("s7_int_rst", {31'd0, bus.interrupt}, 32'd0);
    chk("s7_pend_rst", {24'd0, bus.pending}, 32'h00);

    // Higher-priority source while servicing
    wr_mask(8'h00);
    bus.irq_in = 8'h40; tick(); bus.irq_in = 8'h00; tick();
    bus.ack = 1; tick();
    chk("s8_isr6", {24'd0, bus.in_service}, 32'h40);
    bus.irq_in = 8'h02; tick(); bus.irq_in = 8'h00; tick();
`ifdef INTR_NEST_EN
    chk("s8_nest_int", {31'd0, bus.interrupt}, 32'd1);
    chk("s8_nest_vec", {29'd0, bus.vector_id}, 32'd1);
    bus.ack = 1; tick();
    chk("s8_isr42", {24'd0, bus.in_service}, 32'h42);
    bus.iret = 1; tick();
    chk("s8_isr40", {24'd0, bus.in_service}, 32'h40);
    bus.iret = 1; tick();
    chk("s8_isr00", {24'd0, bus.in_service}, 32'h00);
`else
    chk("s8_no_nest", {31'd0, bus.interrupt}, 32'd0);
    bus.iret = 1; tick();
    chk("s8_isr00", {24'd0, bus.in_service}, 32'h00);
    tick();
    chk("s8_int", {31'd0, bus.interrupt}, 32'd1);
    chk("s8_vec", {29'd0, bus.vector_id}, 32'd1);
    bus.ack = 1; tick(); bus.iret = 1; tick();
`endif

    // Randomized traffic
    lvl = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 700 == 0) begin
        reset = 1;
      end else begin
        reset = 0;
      end
      if ($urandom_range(0, 9) == 0) lvl = ~lvl;
      r = 8'($urandom & $urandom & $urandom);
      bus.irq_in = (r & 8'hEF) | {3'd0, lvl, 4'd0};
      if ($urandom_range(0, 39) == 0) begin
        bus.mask_wr = 1;
        bus.mask_data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      end
      if ((m_int && $urandom_range(0, 2) == 0) || $urandom_range(0, 199) == 0) bus.ack = 1;
      if ((m_isr != 0 && $urandom_range(0, 4) == 0) || $urandom_range(0, 199) == 0) bus.iret = 1;
      tick();
    end
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter EDGE_MASK, default 8'hFF, per-source trigger type: bit=1 rising-edge, bit=0 level-high.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 irq_in  input  8  raw interrupt sources; index 0 is highest priority.
REQ-005 mask_wr  input  1  single-cycle strobe loading mask_data into mask.
REQ-006 mask_data  input  8  new mask value; bit=1 masks the source.
REQ-007 ack  input  1  one-cycle pulse from the PC controller when an interrupt is taken (save_accum cycle).
REQ-008 iret  input  1  one-cycle pulse when a return-from-interrupt retires.
REQ-009 interrupt  output  1  registered request to the PC controller.
REQ-010 vector_id  output  3  index of the source being requested or most recently acknowledged.
REQ-011 pending  output  8  registered pending vector, before masking.
REQ-012 mask  output  8  current mask register.
REQ-013 in_service  output  8  one bit per source currently being serviced.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 Edge sources: irq_in sampled into a previous-value register; 0->1 sets pending bit at the next edge.
REQ-016 Level sources: pending bit equals irq_in registered one cycle.
REQ-017 Eligible = pending & ~mask & ~in_service, further gated per REQ-020 / REQ-032.
REQ-018 Arbitration: fixed priority, lowest eligible index wins.
REQ-019 FSM states IDLE, REQ, SERVICE; encoding free.
REQ-020 IDLE: if any source eligible -> REQ; interrupt=1 and vector_id=winner, both registered, visible the cycle after eligibility.
REQ-021 REQ: interrupt and vector_id held stable until ack, even if the source deasserts or becomes masked (request is committed once raised).
REQ-022 REQ + ack: set in_service[vector_id]; clear pending[vector_id] if edge type; interrupt=0 next cycle; -> SERVICE.
REQ-023 Edge on the acked source in the ack cycle: pending bit stays set (set wins over clear).
REQ-024 SERVICE + iret: clear lowest-index set in_service bit; if none remain -> IDLE, else stay SERVICE.
REQ-025 ack outside REQ: no state change, err=1.
REQ-026 iret with in_service==0: no state change, err=1.
REQ-027 ack and iret in same cycle: ack processed per REQ-022, iret ignored, err=1.
REQ-028 mask_wr: mask updated next edge; a pending masked source never raises interrupt; it is not lost.
REQ-029 interrupt never asserted in SERVICE without INTR_NEST_EN.
REQ-030 err cleared only by reset.

Reset
REQ-031 On reset: FSM IDLE, interrupt=0, vector_id=0, pending=0, edge history=0, mask=8'hFF, in_service=0, err=0; reset mid-request drops the request with no ack expected.

Configuration
REQ-032 Macro INTR_NEST_EN: when defined, in SERVICE a source with index lower than the lowest set in_service bit is eligible and moves FSM to REQ (nested request); ack then adds its in_service bit; iret retires innermost first per REQ-024. Undefined: no request raised while in_service!=0.

Verification
REQ-033 Reset, mask_wr 8'h00, pulse irq_in[3] one cycle -> interrupt=1 two cycles later, vector_id=3; ack -> interrupt=0, in_service=8'h08, pending=0; iret -> in_service=0, IDLE.
REQ-034 irq_in[5] and irq_in[2] rise together, mask 0 -> vector_id=2; after ack+iret, second request vector_id=5.
REQ-035 mask=8'h01, pulse irq_in[0] -> no interrupt, pending=8'h01; write mask 0 -> interrupt next-but-one cycle, vector_id=0.
REQ-036 Level source 4 (EDGE_MASK=8'hEF) dropped while in REQ -> interrupt held until ack, vector_id=4.
REQ-037 ack with interrupt=0 -> err=1, all other state unchanged; iret with in_service=0 -> err stays 1.
REQ-038 INTR_NEST_EN: servicing source 6, pulse irq_in[1] -> interrupt=1, vector_id=1; ack -> in_service=8'h42; iret -> 8'h40; iret -> 0; without macro, irq_in[1] waits until first iret.
